// File: rtl/ard_write_bridge.sv
// rtl/ard_write_bridge.sv - Arduino byte-frame receiver driving the DRAM Arduino write port
// Define ARDW_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module ard_write_bridge #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int ADDR_BYTES  = 3,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ard_data,
  input  logic              ard_strobe,
  output logic              ard_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              err,
  output logic [7:0]        frame_cnt
);
  localparam int AW_FULL = 8 * ADDR_BYTES;
  localparam int CW      = (ADDR_BYTES > 2) ? $clog2(ADDR_BYTES) : 1;
  localparam int TW      = $clog2(TIMEOUT_CYC);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
`ifdef ARDW_CHECKSUM_EN
  localparam logic [2:0] CHK   = 3'd4;
`endif

  logic [2:0]         state;
  logic               strobe_meta;
  logic               strobe_sync;
  logic               strobe_hist;
  logic [CW-1:0]      cnt;
  logic [TW-1:0]      tcnt;
  logic [AW_FULL-1:0] addr_asm;
  logic [7:0]         data_lo;
`ifdef ARDW_CHECKSUM_EN
  logic [7:0]         data_hi;
  logic [7:0]         csum;
`endif

  logic       capture;
  logic       in_frame;
  logic       timeout_hit;
  logic       commit;
  logic [7:0] commit_hi;

  assign capture  = strobe_sync & ~strobe_hist;
  assign busy     = (state != IDLE);
`ifdef ARDW_CHECKSUM_EN
  assign in_frame = (state == ADDR) || (state == DATA) || (state == CHK);
`else
  assign in_frame = (state == ADDR) || (state == DATA);
`endif
  // A capture on the expiry cycle still counts; the frame survives.
  assign timeout_hit = in_frame && !capture && (tcnt == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    commit    = 1'b0;
    commit_hi = ard_data;
    if (capture) begin
`ifdef ARDW_CHECKSUM_EN
      if ((state == CHK) && (ard_data == csum)) begin
        commit    = 1'b1;
        commit_hi = data_hi;
      end
`else
      if ((state == DATA) && (cnt != '0)) begin
        commit = 1'b1;
      end
`endif
    end
  end

  generate
    if (AW_FULL > ADDR_W) begin : g_addr_pad
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr_asm[AW_FULL-1:ADDR_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      strobe_meta <= 1'b0;
      strobe_sync <= 1'b0;
      strobe_hist <= 1'b0;
      ard_ack     <= 1'b0;
      cnt         <= '0;
      tcnt        <= '0;
      addr_asm    <= '0;
      data_lo     <= '0;
`ifdef ARDW_CHECKSUM_EN
      data_hi     <= '0;
      csum        <= '0;
`endif
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      err         <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      strobe_meta <= ard_strobe;
      strobe_sync <= strobe_meta;
      strobe_hist <= strobe_sync;
      ard_ack     <= strobe_hist;
      mem_we      <= 1'b0;

      if (!in_frame || capture) tcnt <= '0;
      else                      tcnt <= tcnt + TW'(1);

      if (capture && ((state == IDLE) || (state == ADDR))) begin
        for (int i = 0; i < ADDR_BYTES; i++) begin
          if (cnt == CW'(i)) addr_asm[i*8 +: 8] <= ard_data;
        end
      end

      if (commit) begin
        mem_we    <= 1'b1;
        mem_addr  <= addr_asm[ADDR_W-1:0];
        mem_wdata <= DATA_W'({commit_hi, data_lo});
        frame_cnt <= frame_cnt + 8'd1;
      end

      case (state)
        IDLE: begin
          if (capture) begin
            err <= 1'b0;
`ifdef ARDW_CHECKSUM_EN
            csum <= ard_data;
`endif
            if (ADDR_BYTES == 1) begin
              state <= DATA;
              cnt   <= '0;
            end else begin
              state <= ADDR;
              cnt   <= CW'(1);
            end
          end
        end
        ADDR: begin
          if (timeout_hit) begin
            err   <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
          end else if (capture) begin
`ifdef ARDW_CHECKSUM_EN
            csum <= csum ^ ard_data;
`endif
            if (cnt == CW'(ADDR_BYTES - 1)) begin
              state <= DATA;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DATA: begin
          if (timeout_hit) begin
            err   <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
          end else if (capture) begin
`ifdef ARDW_CHECKSUM_EN
            csum <= csum ^ ard_data;
`endif
            if (cnt == '0) begin
              data_lo <= ard_data;
              cnt     <= CW'(1);
            end else begin
              cnt <= '0;
`ifdef ARDW_CHECKSUM_EN
              data_hi <= ard_data;
              state   <= CHK;
`else
              state   <= WRITE;
`endif
            end
          end
        end
`ifdef ARDW_CHECKSUM_EN
        CHK: begin
          if (timeout_hit) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (capture) begin
            if (commit) begin
              state <= WRITE;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
        end
`endif
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
